serial_tx_ctrl: RTL and testbench

SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

---
 rtl/serial_tx_pkg.sv | 17 +
 rtl/flex_counter.sv | 41 ++++
 rtl/serial_tx_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_tx_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial transmit controller.
package serial_tx_pkg;

  localparam int unsigned NUM_BITS_DEF   = 8;
  localparam int unsigned BIT_PERIOD_DEF = 10;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Wrapping up-counter with synchronous clear and a registered rollover flag.
module flex_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise wrap at rollover_val.
  always_comb begin
    count_d = count;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count == rollover_val) begin
        count_d = '0;
      end else begin
        count_d = count + WIDTH'(1);
      end
    end
  end

  // Flag is registered alongside count so it is high exactly while count==rollover_val.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count         <= count_d;
      rollover_flag <= (count_d == rollover_val);
    end
  end

endmodule

// File: rtl/serial_tx_ctrl.sv
// Frame sequencer driving an external parallel-to-serial shifter.
module serial_tx_ctrl
  import serial_tx_pkg::*;
#(
  parameter int unsigned NUM_BITS   = NUM_BITS_DEF,
  parameter int unsigned BIT_PERIOD = BIT_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_valid,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_abort,
  output logic                tx_ready,
  output logic                tx_done,
  output logic                load_enable,
  output logic                shift_enable,
  output logic [NUM_BITS+1:0] sr_data
);

  localparam int unsigned FRAME_W = NUM_BITS + 2;
  localparam int unsigned TIMER_W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_PERIOD - 1);
  localparam logic [TIMER_W-1:0] TIMER_PRE  = TIMER_W'(BIT_PERIOD - 2);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_W - 1);

  tx_state_t            state;
  tx_state_t            next_state;
  logic [TIMER_W-1:0]   timer;
  logic                 timer_wrap;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_cnt_d;
  logic                 abort_pend;
  logic                 abort_pend_d;
  logic [FRAME_W-1:0]   sr_data_d;
  logic                 load_en_d;
  logic                 shift_en_d;
  logic                 tx_done_d;
  logic                 accept;
  logic                 abort_hit;
  logic                 last_shift;

  // Ready is held low during reset so nothing is accepted before the FSM is known.
  assign tx_ready   = (state == IDLE) && !tx_abort && !rst;
  assign accept     = tx_valid && tx_ready;
  assign abort_hit  = tx_abort && ((state == LOAD) || (state == SHIFT));
  assign last_shift = (state == SHIFT) && timer_wrap && (bit_cnt == CNT_LAST);

  // Bit timer: runs only in SHIFT, held at zero whenever SHIFT is not next.
  flex_counter #(
    .WIDTH (TIMER_W)
  ) u_bit_timer (
    .clk           (clk),
    .rst           (rst),
    .clear         (next_state != SHIFT),
    .count_enable  (state == SHIFT),
    .rollover_val  (TIMER_LAST),
    .count         (timer),
    .rollover_flag (timer_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = LOAD;
      LOAD:    next_state = tx_abort ? IDLE : SHIFT;
      SHIFT: begin
        if (tx_abort) begin
          next_state = IDLE;
        end else if (last_shift) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes are predicted one cycle ahead.
  always_comb begin
    sr_data_d    = sr_data;
    load_en_d    = abort_pend;
    shift_en_d   = 1'b0;
    tx_done_d    = 1'b0;
    abort_pend_d = 1'b0;
    bit_cnt_d    = bit_cnt;

    if (accept) begin
      sr_data_d = {STOP_BIT, tx_data, START_BIT};
      load_en_d = 1'b1;
    end

    // Abort parks the shifter word at idle-high and reloads it one cycle later.
    if (abort_hit) begin
      sr_data_d    = '1;
      abort_pend_d = 1'b1;
    end

    if ((state == SHIFT) && !tx_abort && (timer == TIMER_PRE)) begin
      shift_en_d = 1'b1;
    end

    if (last_shift && !tx_abort) begin
      tx_done_d = 1'b1;
    end

    if (next_state != SHIFT) begin
      bit_cnt_d = '0;
    end else if ((state == SHIFT) && timer_wrap) begin
      bit_cnt_d = bit_cnt + CNT_W'(1);
    end
  end

  // Output and bit-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_data      <= '1;
      load_enable  <= 1'b0;
      shift_enable <= 1'b0;
      tx_done      <= 1'b0;
      abort_pend   <= 1'b0;
      bit_cnt      <= '0;
    end else begin
      sr_data      <= sr_data_d;
      load_enable  <= load_en_d;
      shift_enable <= shift_en_d;
      tx_done      <= tx_done_d;
      abort_pend   <= abort_pend_d;
      bit_cnt      <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Scoreboard bench for serial_tx_ctrl with a model LSB-first shifter on its outputs.
module tb_serial_tx_ctrl;

  localparam int unsigned NB = 8;
  localparam int unsigned BP = 4;
  localparam int unsigned FW = NB + 2;

  logic          clk;
  logic          rst;
  logic          tx_valid;
  logic [NB-1:0] tx_data;
  logic          tx_abort;
  logic          tx_ready;
  logic          tx_done;
  logic          load_enable;
  logic          shift_enable;
  logic [FW-1:0] sr_data;

  logic [FW-1:0] shreg;
  logic          line;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;

  logic [FW-1:0] q_exp[$];
  int            q_acc[$];

  logic          in_frame = 1'b0;
  logic [FW-1:0] cur_word;
  logic [FW-1:0] got_w;
  int            cur_acc;
  int            nbits;
  int            last_ev;

  serial_tx_ctrl #(
    .NUM_BITS   (NB),
    .BIT_PERIOD (BP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_abort     (tx_abort),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .load_enable  (load_enable),
    .shift_enable (shift_enable),
    .sr_data      (sr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream shifter model: load, shift LSB-first, fill with ones.
  always @(posedge clk) begin
    if (rst) begin
      shreg <= '1;
    end else if (load_enable) begin
      shreg <= sr_data;
    end else if (shift_enable) begin
      shreg <= {1'b1, shreg[FW-1:1]};
    end
  end
  assign line = shreg[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor: push on accept, pop on load, rebuild the serial word from the line.
  always @(negedge clk) begin
    logic [FW-1:0] exp_w;
    int            acc_c;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        q_exp.push_back({1'b1, tx_data, 1'b0});
        q_acc.push_back(cyc);
      end
      if (load_enable) begin
        check("load_shift_excl", 32'(shift_enable), 32'd0);
        if (sr_data == '1) begin
          in_frame = 1'b0;
        end else if (q_exp.size() == 0) begin
          check("load_unexpected", 32'd1, 32'd0);
        end else begin
          exp_w = q_exp.pop_front();
          acc_c = q_acc.pop_front();
          check("frame_word", 32'(sr_data), 32'(exp_w));
          check("load_latency", 32'(cyc - acc_c), 32'd1);
          cur_word = exp_w;
          cur_acc  = acc_c;
          in_frame = 1'b1;
          nbits    = 0;
          last_ev  = cyc;
          got_w    = '1;
        end
      end
      if (shift_enable && in_frame) begin
        check("bit_period", 32'(cyc - last_ev), 32'(BP));
        last_ev = cyc;
        if (nbits < int'(FW)) got_w[nbits] = line;
        nbits++;
      end
      if (tx_done) begin
        n_done++;
        check("done_in_frame", 32'(in_frame), 32'd1);
        if (in_frame) begin
          check("done_bits", 32'(nbits), 32'(FW));
          check("serial_word", 32'(got_w), 32'(cur_word));
          check("done_latency", 32'(cyc - cur_acc), 32'(FW * BP + 2));
        end
        in_frame = 1'b0;
      end
    end
  end

  // Drive one payload for a single cycle from IDLE and return the accept cycle.
  task automatic send(input logic [NB-1:0] d, output int acc_cyc);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    check("ready_at_accept", 32'(tx_ready), 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = d ^ 8'h5A;
  endtask

  // Wait (bounded) for tx_done, then confirm ready returns the next cycle.
  task automatic wait_done(input int limit, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    if (done_cyc >= 0) begin
      check("ready_in_done", 32'(tx_ready), 32'd0);
      @(negedge clk);
      check("ready_after_done", 32'(tx_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int dc;
    int acc2[2];
    int n_acc;
    int done_before;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_abort = 1'b0;
    tx_data  = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_load", 32'(load_enable), 32'd0);
    check("rst_shift", 32'(shift_enable), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_sr_data", 32'(sr_data), 32'h3FF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    // Single frame 0xA5.
    send(8'hA5, acc);
    wait_done(100, dc);
    check("a5_done_at", 32'(dc - acc), 32'd42);

    // Back-to-back frames with tx_valid held high.
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    n_acc    = 0;
    for (int i = 0; i < 200 && n_acc < 2; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        acc2[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 1) tx_data = 8'hFF;
      if (n_acc == 2) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd2);
    if (n_acc == 2) check("b2b_spacing", 32'(acc2[1] - acc2[0]), 32'd43);
    wait_done(100, dc);

    // Abort mid-frame at cycle 10 of a 0x3C frame.
    done_before = n_done;
    send(8'h3C, acc);
    repeat (9) @(posedge clk);
    #1 tx_abort = 1'b1;
    @(posedge clk); #1;
    tx_abort = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", 32'(tx_ready), 32'd1);
    check("abort_no_load_yet", 32'(load_enable), 32'd0);
    check("abort_sr_ones", 32'(sr_data), 32'h3FF);
    @(negedge clk);
    check("abort_load_at", 32'(cyc - acc), 32'd12);
    check("abort_load", 32'(load_enable), 32'd1);
    check("abort_load_word", 32'(sr_data), 32'h3FF);
    @(negedge clk);
    check("abort_line_high", 32'(line), 32'd1);
    repeat (50) @(negedge clk);
    check("abort_no_done", 32'(n_done), 32'(done_before));
    check("abort_line_idle", 32'(line), 32'd1);

    // Reset during SHIFT, then a clean 0x81 frame.
    send(8'h55, acc);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("midrst_load", 32'(load_enable), 32'd0);
    check("midrst_shift", 32'(shift_enable), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);
    check("midrst_sr_data", 32'(sr_data), 32'h3FF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", 32'(tx_ready), 32'd1);
    check("midrst_line", 32'(line), 32'd1);
    check("midrst_no_done", 32'(n_done), 32'(done_before));
    send(8'h81, acc);
    wait_done(100, dc);
    check("x81_done_at", 32'(dc - acc), 32'd42);

    // Abort and valid together in IDLE: accept only once abort drops.
    @(posedge clk); #1;
    tx_abort = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_blocks_ready", 32'(tx_ready), 32'd0);
      check("abort_blocks_load", 32'(load_enable), 32'd0);
    end
    @(posedge clk); #1;
    tx_abort = 1'b0;
    @(negedge clk);
    check("abort_drop_ready", 32'(tx_ready), 32'd1);
    acc = cyc;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_done(100, dc);
    check("x5a_done_at", 32'(dc - acc), 32'd42);

    // Nothing lost or duplicated.
    repeat (5) @(negedge clk);
    check("queue_empty", 32'(q_exp.size()), 32'd0);
    check("frames_done", 32'(n_done), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
